// File: rtl/cpx_bfly_pipe_if.sv
// Valid/ready bundle for the pipelined complex butterfly: operand side,
// result side and the sticky overflow flag.
interface cpx_bfly_pipe_if #(
  parameter int W     = 16,
  parameter int LOG2N = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [2*W-1:0]     a;
  logic [2*W-1:0]     b;
  logic [LOG2N-1:0]   tw_idx;
  logic               inverse;
  logic               scale;
  logic               out_valid;
  logic               out_ready;
  logic [2*W-1:0]     y0;
  logic [2*W-1:0]     y1;
  logic               ovf;
  logic               ovf_clr;

  modport master (
    output in_valid, a, b, tw_idx, inverse, scale, out_ready, ovf_clr,
    input  in_ready, out_valid, y0, y1, ovf
  );

  modport slave (
    input  in_valid, a, b, tw_idx, inverse, scale, out_ready, ovf_clr,
    output in_ready, out_valid, y0, y1, ovf
  );
endinterface

// File: rtl/cpx_bfly_pipe.sv
// Three-stage radix-2 complex butterfly y0 = a + b*W, y1 = a - b*W with a
// constant twiddle ROM, optional halving, saturation and full back-pressure.
module cpx_bfly_pipe #(
  parameter int W     = 16,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  cpx_bfly_pipe_if.slave   bus
);

  localparam int N  = 1 << LOG2N;
  localparam int PW = 2 * W;
  localparam int SW = W + 2;
  localparam logic signed [PW:0]   HALF = (PW+1)'(2 ** (W-3));
  localparam logic signed [SW-1:0] SMAX = SW'(2 ** (W-1) - 1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(2 ** (W-1)));

  // Twiddle entry in Q2.(W-2), rounded to nearest (half away from zero).
  function automatic logic signed [W-1:0] tw_val(input int k, input bit im);
    real ang;
    real v;
    int  iv;
    ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    v   = im ? -$sin(ang) : $cos(ang);
    v   = v * real'(1 << (W-2));
    iv  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return iv[W-1:0];
  endfunction

  function automatic logic signed [SW-1:0] rnd_prod(input logic signed [PW:0] x);
    logic signed [PW:0] t;
    t = x + HALF;
    return SW'(t >>> (W-2));
  endfunction

  function automatic logic signed [SW-1:0] halve(input logic signed [SW-1:0] s);
    return (s + SW'(1)) >>> 1;
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] s);
    return (s > SMAX) || (s < SMIN);
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] s);
    if (s > SMAX)      return W'(SMAX);
    else if (s < SMIN) return W'(SMIN);
    else               return W'(s);
  endfunction

  logic signed [W-1:0] rom_wr [N];
  logic signed [W-1:0] rom_wi [N];

  for (genvar k = 0; k < N; k++) begin : g_rom
    localparam logic signed [W-1:0] WR_K = tw_val(k, 1'b0);
    localparam logic signed [W-1:0] WI_K = tw_val(k, 1'b1);
    assign rom_wr[k] = WR_K;
    assign rom_wi[k] = WI_K;
  end

  logic                 vld_p0, vld_p1, vld_p2;
  logic                 scale_p0, scale_p1;
  logic signed [W-1:0]  a_re_p0, a_im_p0, b_re_p0, b_im_p0, wr_p0, wi_p0;
  logic signed [W-1:0]  a_re_p1, a_im_p1;
  logic signed [PW-1:0] prr_p1, pii_p1, pri_p1, pir_p1;
  logic signed [W-1:0]  y0_re_p2, y0_im_p2, y1_re_p2, y1_im_p2;
  logic                 ovf;

  logic                 stall, adv;
  logic signed [PW:0]   sum_re, sum_im;
  logic signed [SW-1:0] p_re, p_im, s0_re, s0_im, s1_re, s1_im;
  logic                 sat_any;

  assign stall = vld_p2 & ~bus.out_ready;
  assign adv   = ~stall;

  always_comb begin
    sum_re  = (PW+1)'(prr_p1) - (PW+1)'(pii_p1);
    sum_im  = (PW+1)'(pri_p1) + (PW+1)'(pir_p1);
    p_re    = rnd_prod(sum_re);
    p_im    = rnd_prod(sum_im);
    s0_re   = SW'(a_re_p1) + p_re;
    s0_im   = SW'(a_im_p1) + p_im;
    s1_re   = SW'(a_re_p1) - p_re;
    s1_im   = SW'(a_im_p1) - p_im;
    if (scale_p1) begin
      s0_re = halve(s0_re);
      s0_im = halve(s0_im);
      s1_re = halve(s1_re);
      s1_im = halve(s1_im);
    end
    sat_any = clips(s0_re) | clips(s0_im) | clips(s1_re) | clips(s1_im);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      scale_p0 <= 1'b0;
      scale_p1 <= 1'b0;
      a_re_p0  <= '0;
      a_im_p0  <= '0;
      b_re_p0  <= '0;
      b_im_p0  <= '0;
      wr_p0    <= '0;
      wi_p0    <= '0;
      a_re_p1  <= '0;
      a_im_p1  <= '0;
      prr_p1   <= '0;
      pii_p1   <= '0;
      pri_p1   <= '0;
      pir_p1   <= '0;
      y0_re_p2 <= '0;
      y0_im_p2 <= '0;
      y1_re_p2 <= '0;
      y1_im_p2 <= '0;
    end else if (adv) begin
      // S1: capture operands and the direction-selected twiddle
      vld_p0   <= bus.in_valid;
      scale_p0 <= bus.scale;
      a_re_p0  <= bus.a[2*W-1:W];
      a_im_p0  <= bus.a[W-1:0];
      b_re_p0  <= bus.b[2*W-1:W];
      b_im_p0  <= bus.b[W-1:0];
      wr_p0    <= rom_wr[bus.tw_idx];
      wi_p0    <= bus.inverse ? -rom_wi[bus.tw_idx] : rom_wi[bus.tw_idx];
      // S2: full-precision partial products
      vld_p1   <= vld_p0;
      scale_p1 <= scale_p0;
      a_re_p1  <= a_re_p0;
      a_im_p1  <= a_im_p0;
      prr_p1   <= PW'(b_re_p0) * PW'(wr_p0);
      pii_p1   <= PW'(b_im_p0) * PW'(wi_p0);
      pri_p1   <= PW'(b_re_p0) * PW'(wi_p0);
      pir_p1   <= PW'(b_im_p0) * PW'(wr_p0);
      // S3: round, add/subtract, optional halving, saturate
      vld_p2   <= vld_p1;
      y0_re_p2 <= sat(s0_re);
      y0_im_p2 <= sat(s0_im);
      y1_re_p2 <= sat(s1_re);
      y1_im_p2 <= sat(s1_im);
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ovf <= 1'b0;
    else if (adv & vld_p1 & sat_any)  ovf <= 1'b1;
    else if (bus.ovf_clr)             ovf <= 1'b0;
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld_p2;
  assign bus.y0        = {y0_re_p2, y0_im_p2};
  assign bus.y1        = {y1_re_p2, y1_im_p2};
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_cpx_bfly_pipe.sv
// Directed bench for cpx_bfly_pipe with an arithmetic reference model and a
// result scoreboard checked every cycle the output is valid.
module tb_cpx_bfly_pipe;
  localparam int W     = 16;
  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpx_bfly_pipe_if #(.W(W), .LOG2N(LOG2N)) bus ();
  cpx_bfly_pipe #(.W(W), .LOG2N(LOG2N)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [2*W-1:0] y0; logic [2*W-1:0] y1; } res_t;

  res_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   retired = 0;

  logic [31:0] bp_a   [5] = '{32'h0100_0200, 32'hF000_1000, 32'h1234_5678, 32'h8000_7FFF, 32'h0000_0000};
  logic [31:0] bp_b   [5] = '{32'h0300_0400, 32'h2000_E000, 32'h3000_D000, 32'h7FFF_8000, 32'hC000_4000};
  int          bp_k   [5] = '{3, 5, 7, 4, 6};
  bit          bp_inv [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  bit          bp_sc  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic longint rnd(input real v);
    return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction

  function automatic longint clip(input longint s);
    longint hi, lo;
    hi = (longint'(1) << (W-1)) - 1;
    lo = -(longint'(1) << (W-1));
    return (s > hi) ? hi : ((s < lo) ? lo : s);
  endfunction

  function automatic res_t model(input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                                 input int k, input bit inv, input bit sc);
    real    ang, one;
    longint ar, ai, br, bi, wr, wi, pr, pim, h;
    longint s [4];
    res_t   r;
    ang = 2.0 * 3.14159265358979323846 * real'(k % N) / real'(N);
    one = real'(longint'(1) << (W-2));
    wr  = rnd($cos(ang) * one);
    wi  = rnd(-$sin(ang) * one);
    if (inv) wi = -wi;
    ar  = longint'($signed(a[2*W-1:W]));
    ai  = longint'($signed(a[W-1:0]));
    br  = longint'($signed(b[2*W-1:W]));
    bi  = longint'($signed(b[W-1:0]));
    h   = longint'(1) << (W-3);
    pr  = (br * wr - bi * wi + h) >>> (W-2);
    pim = (br * wi + bi * wr + h) >>> (W-2);
    s[0] = ar + pr;  s[1] = ai + pim;
    s[2] = ar - pr;  s[3] = ai - pim;
    for (int i = 0; i < 4; i++) begin
      if (sc) s[i] = (s[i] + 1) >>> 1;
      s[i] = clip(s[i]);
    end
    r.y0 = {W'(s[0]), W'(s[1])};
    r.y1 = {W'(s[2]), W'(s[3])};
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a, bus.b, int'(bus.tw_idx), bus.inverse, bus.scale));
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y0=%h y1=%h, required no result", bus.y0, bus.y1);
      end else begin
        chk("model_y0", bus.y0, exp_q[0].y0);
        chk("model_y1", bus.y1, exp_q[0].y1);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          retired++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input int k,
                       input bit inv, input bit sc);
    bus.a        = a;
    bus.b        = b;
    bus.tw_idx   = LOG2N'(k);
    bus.inverse  = inv;
    bus.scale    = sc;
    bus.in_valid = 1'b1;
  endtask

  // Ends two edges after the accepting edge, with the result on the outputs.
  task automatic send_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input int k, input bit inv, input bit sc,
                          input logic [31:0] e0, input logic [31:0] e1);
    res_t r;
    r = model(a, b, k, inv, sc);
    chk({nm, "_model_y0"}, r.y0, e0);
    chk({nm, "_model_y1"}, r.y1, e1);
    drive(a, b, k, inv, sc);
    chk({nm, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk({nm, "_valid_after_s1"}, bus.out_valid, 0);
    tick();
    chk({nm, "_valid_after_s2"}, bus.out_valid, 0);
    tick();
    chk({nm, "_valid_after_s3"}, bus.out_valid, 1);
    chk({nm, "_y0"}, bus.y0, e0);
    chk({nm, "_y1"}, bus.y1, e1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          base;
    int          guard;
    logic [31:0] held;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.tw_idx = '0;
    bus.inverse = 1'b0; bus.scale = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0;
    tick();
    tick();
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_y0", bus.y0, 0);
    chk("reset_ovf", bus.ovf, 0);
    rst = 1'b0;
    tick();

    send_one("identity", 32'h2000_0000, 32'h1000_0000, 0, 1'b0, 1'b0, 32'h3000_0000, 32'h1000_0000);
    chk("identity_ovf", bus.ovf, 0);
    send_one("minus_j", 32'h2000_0000, 32'h1000_0000, 2, 1'b0, 1'b0, 32'h2000_F000, 32'h2000_1000);
    send_one("plus_j", 32'h2000_0000, 32'h1000_0000, 2, 1'b1, 1'b0, 32'h2000_1000, 32'h2000_F000);
    send_one("irrational", 32'h0000_0000, 32'h4000_0000, 1, 1'b0, 1'b0, 32'h2D41_D2BF, 32'hD2BF_2D41);

    send_one("saturate", 32'h6000_0000, 32'h4000_0000, 0, 1'b0, 1'b0, 32'h7FFF_0000, 32'h2000_0000);
    chk("sat_ovf_set", bus.ovf, 1);
    tick();
    chk("sat_ovf_sticky", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 0);
    send_one("scaled", 32'h6000_0000, 32'h4000_0000, 0, 1'b0, 1'b1, 32'h5000_0000, 32'h1000_0000);
    chk("scaled_ovf", bus.ovf, 0);
    bus.ovf_clr = 1'b1;
    send_one("set_vs_clr", 32'h6000_0000, 32'h4000_0000, 0, 1'b0, 1'b0, 32'h7FFF_0000, 32'h2000_0000);
    chk("set_wins_over_clr", bus.ovf, 1);
    tick();
    chk("clr_after_set", bus.ovf, 0);
    bus.ovf_clr = 1'b0;
    tick();

    // Back-pressure: five samples offered with the sink stalled.
    base = retired;
    acc  = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive(bp_a[acc], bp_b[acc], bp_k[acc], bp_inv[acc], bp_sc[acc]);
      @(posedge clk);
      if (bus.in_ready) acc++;
      #1;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    held = bus.y0;
    tick();
    chk("bp_hold_y0", bus.y0, held);
    chk("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    guard = 0;
    while ((acc < 5 || exp_q.size() != 0) && guard < 40) begin
      if (acc < 5) drive(bp_a[acc], bp_b[acc], bp_k[acc], bp_inv[acc], bp_sc[acc]);
      else         bus.in_valid = 1'b0;
      @(posedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("bp_drain_in_time", guard < 40, 1);
    chk("bp_all_accepted", acc, 5);
    chk("bp_all_retired", retired - base, 5);
    tick();
    chk("bp_ovf_from_sample3", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;

    // Reset with three samples in flight, the oldest one saturating.
    bus.out_ready = 1'b0;
    drive(32'h6000_0000, 32'h4000_0000, 0, 1'b0, 1'b0);
    tick();
    drive(32'h2000_0000, 32'h1000_0000, 0, 1'b0, 1'b0);
    tick();
    drive(32'h2000_0000, 32'h1000_0000, 2, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    chk("pre_reset_valid", bus.out_valid, 1);
    chk("pre_reset_ovf", bus.ovf, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_reset_out_valid", bus.out_valid, 0);
    chk("mid_reset_in_ready", bus.in_ready, 1);
    chk("mid_reset_ovf", bus.ovf, 0);
    chk("mid_reset_y0", bus.y0, 0);
    chk("mid_reset_y1", bus.y1, 0);
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    chk("post_reset_out_valid", bus.out_valid, 0);
    send_one("after_reset", 32'h2000_0000, 32'h1000_0000, 0, 1'b0, 1'b0, 32'h3000_0000, 32'h1000_0000);
    chk("after_reset_ovf", bus.ovf, 0);
    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
